// File: rtl/usb11_recv.sv
`default_nettype none
// -----------------------------------------------------------------------------
// usb11_recv: low-speed USB 1.1 receiver (SYNC check, NRZI, destuff, framing)
// Revision: 1.0
// -----------------------------------------------------------------------------
module usb11_recv #(
  parameter int CLKS_PER_BIT   = 8,
  parameter int SE0_RESET_CLKS = 30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic       rx_enable,
  output logic [7:0] rbyte,
  output logic       rbyte_wr,
  output logic       pkt_active,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic [1:0] line_state,
  output logic       se0_long
);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int JW = $clog2(2 * CLKS_PER_BIT + 1);
  localparam int SW = $clog2(SE0_RESET_CLKS + 1);
  localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SMP = PW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [JW-1:0] J_IDLE    = JW'(2 * CLKS_PER_BIT);
  localparam logic [SW-1:0] SE0_MAX   = SW'(SE0_RESET_CLKS);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, ls_q, ls_prev_q;
  logic [PW-1:0] phase_q, phase_w;
  logic [SW-1:0] se0cnt_q, se0cnt_d;
  logic [1:0]    samp_prev_q, samp_prev_d;
  logic [2:0]    bitcnt_q, bitcnt_d, ones_q, ones_d;
  logic [7:0]    shift_q, shift_d, rbyte_q, rbyte_d, byte_w;
  logic          got_byte_q, got_byte_d, eop2_q, eop2_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic          rbyte_wr_q, rbyte_wr_d, pkt_end_q, pkt_end_d, pkt_err_q, pkt_err_d;
  logic          pkt_active_q;
  logic          edge_w, sample_w, bit_w;

  // Phase restarts on every line transition so sampling tracks the sender.
  assign edge_w   = (ls_q != ls_prev_q);
  assign phase_w  = (edge_w || phase_q == PHASE_MAX) ? '0 : phase_q + 1'b1;
  assign sample_w = (phase_w == PHASE_SMP);
  assign bit_w    = (ls_q == samp_prev_q);
  assign byte_w   = {bit_w, shift_q[7:1]};
  assign se0cnt_d = (ls_q != LS_SE0) ? '0 :
                    (se0cnt_q == SE0_MAX) ? se0cnt_q : se0cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    samp_prev_d = samp_prev_q;
    bitcnt_d    = bitcnt_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    got_byte_d  = got_byte_q;
    eop2_d      = eop2_q;
    jcnt_d      = '0;
    rbyte_d     = rbyte_q;
    rbyte_wr_d  = 1'b0;
    pkt_end_d   = 1'b0;
    pkt_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (edge_w && ls_prev_q == LS_J && ls_q == LS_K) begin
          state_d     = S_SYNC;
          samp_prev_d = LS_J;
          bitcnt_d    = 3'd0;
          got_byte_d  = 1'b0;
        end
      end
      S_SYNC: begin
        if (sample_w) begin
          if (ls_q == LS_SE0 || ls_q == LS_SE1) begin
            state_d = S_ERR;
          end else begin
            samp_prev_d = ls_q;
            shift_d     = byte_w;
            bitcnt_d    = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_d = (byte_w == 8'h80) ? S_DATA : S_ERR;
              ones_d  = 3'd1;
            end
          end
        end
      end
      S_DATA: begin
        if (sample_w) begin
          if (ls_q == LS_SE0) begin
            state_d = S_EOP;
            eop2_d  = 1'b0;
          end else if (ls_q == LS_SE1 || (ones_q == 3'd6 && bit_w)) begin
            state_d   = S_ERR;
            pkt_end_d = 1'b1;
            pkt_err_d = 1'b1;
          end else begin
            samp_prev_d = ls_q;
            if (ones_q == 3'd6) begin
              ones_d = 3'd0;
            end else begin
              ones_d   = bit_w ? ones_q + 3'd1 : 3'd0;
              shift_d  = byte_w;
              bitcnt_d = bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                rbyte_d    = byte_w;
                rbyte_wr_d = 1'b1;
                got_byte_d = 1'b1;
              end
            end
          end
        end
      end
      S_EOP: begin
        if (sample_w) begin
          if (ls_q == LS_J) begin
            state_d   = S_IDLE;
            pkt_end_d = 1'b1;
            pkt_err_d = (bitcnt_q != 3'd0) || !got_byte_q;
          end else if (ls_q == LS_SE0 && !eop2_q) begin
            eop2_d = 1'b1;
          end else begin
            state_d   = S_ERR;
            pkt_end_d = 1'b1;
            pkt_err_d = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (ls_q == LS_J) begin
          jcnt_d = jcnt_q + 1'b1;
          if (jcnt_q == J_IDLE - 1'b1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rx_enable) begin
      state_d    = S_IDLE;
      rbyte_d    = rbyte_q;
      rbyte_wr_d = 1'b0;
      pkt_end_d  = 1'b0;
      pkt_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      ls_q         <= '0;
      ls_prev_q    <= '0;
      phase_q      <= '0;
      se0cnt_q     <= '0;
      state_q      <= S_IDLE;
      samp_prev_q  <= LS_J;
      bitcnt_q     <= '0;
      ones_q       <= '0;
      shift_q      <= '0;
      got_byte_q   <= 1'b0;
      eop2_q       <= 1'b0;
      jcnt_q       <= '0;
      rbyte_q      <= '0;
      rbyte_wr_q   <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      pkt_active_q <= 1'b0;
    end else begin
      sync_q       <= {dp_in, dm_in};
      ls_q         <= sync_q;
      ls_prev_q    <= ls_q;
      phase_q      <= phase_w;
      se0cnt_q     <= se0cnt_d;
      state_q      <= state_d;
      samp_prev_q  <= samp_prev_d;
      bitcnt_q     <= bitcnt_d;
      ones_q       <= ones_d;
      shift_q      <= shift_d;
      got_byte_q   <= got_byte_d;
      eop2_q       <= eop2_d;
      jcnt_q       <= jcnt_d;
      rbyte_q      <= rbyte_d;
      rbyte_wr_q   <= rbyte_wr_d;
      pkt_end_q    <= pkt_end_d;
      pkt_err_q    <= pkt_err_d;
      pkt_active_q <= (state_d == S_DATA) || (state_d == S_EOP);
    end
  end

  assign rbyte      = rbyte_q;
  assign rbyte_wr   = rbyte_wr_q;
  assign pkt_active = pkt_active_q;
  assign pkt_end    = pkt_end_q;
  assign pkt_err    = pkt_err_q;
  assign line_state = ls_q;
  assign se0_long   = (se0cnt_q == SE0_MAX);

endmodule
`default_nettype wire
